fbw_arbiter: RTL and testbench
==============================

Name: fbw_arbiter

Overview:
- Shares the single frame-buffer write port between two requesters. Typical pairing: requester 0 is the SPI video stream, requester 1 is an on-chip pattern/overlay generator.
- Grants whole transactions: pixel writes plus row store/swap and frame swap.
- Arbitration is round-robin. A new grant is issued only once the back-buffer reports ready.
- A watchdog revokes a grant whose owner has stalled.

Parameters:
- N_ROWS, 64, panel rows; power of 2.
- N_COLS, 64, panel columns.
- TIMEOUT, 4096, idle cycles before a grant is revoked; 0 disables the watchdog.
- LOG_N_ROWS, $clog2(N_ROWS), auto-set.
- LOG_N_COLS, $clog2(N_COLS), auto-set.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- rq_req  in  2  per-requester request; bit i = requester i.
- rq_gnt  out  2  per-requester grant; one-hot or zero.
- rq_row_addr  in  2*LOG_N_ROWS  row address; requester i occupies slice i.
- rq_row_store  in  2  row-store strobe per requester.
- rq_row_swap  in  2  row-swap strobe per requester.
- rq_frame_swap  in  2  frame-swap strobe per requester.
- rq_data  in  48  pixel data; 24 bits per requester.
- rq_col_addr  in  2*LOG_N_COLS  column address per requester.
- rq_wren  in  2  pixel write enable per requester.
- fbw_row_addr  out  LOG_N_ROWS  to frame buffer.
- fbw_row_store  out  1  to frame buffer.
- fbw_row_swap  out  1  to frame buffer.
- fbw_frame_swap  out  1  to frame buffer.
- fbw_data  out  24  to frame buffer.
- fbw_col_addr  out  LOG_N_COLS  to frame buffer.
- fbw_wren  out  1  to frame buffer.
- fbw_row_rdy  in  1  back-buffer ready from frame buffer.
- err_timeout  out  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (async): state IDLE, rq_gnt=0, all fbw_* strobes 0, err_timeout=0, watchdog counter 0, last_owner=1 (so requester 0 wins the first tie).
- States: IDLE, OWN, DRAIN.
- IDLE:
  - If any rq_req bit is set and fbw_row_rdy=1, go to OWN and register the winner's grant.
  - Single requester wins alone. If both request, the winner is ~last_owner.
  - Grant is visible the cycle after req is first sampled, i.e. 1-cycle latency.
- OWN:
  - fbw_* outputs are a combinational mux of the owner's slice, qualified by rq_gnt. Strobes from the non-owner are ignored and never reach fbw_*.
  - Owner req sampled low: drop gnt the next cycle, set last_owner=owner, go to DRAIN. Strobes presented in the cycle req is low are ignored.
  - Watchdog: any owner activity (wren, row_store, row_swap, frame_swap) clears the counter; otherwise the counter increments each cycle.
  - Counter reaching TIMEOUT-1 with no activity: drop gnt, pulse err_timeout for 1 cycle, set last_owner=owner, go to DRAIN.
  - A strobe in the same cycle as the expiry is forwarded and clears the counter; no timeout fires.
- DRAIN:
  - Minimum 1 cycle; fbw_* outputs are 0.
  - Stay while fbw_row_rdy=0, so a row store in flight completes before another owner writes.
  - Exit to IDLE when fbw_row_rdy=1. Arbitration happens in IDLE, so there are at least 2 cycles between grants.
- A timed-out requester that keeps req high re-enters arbitration normally. Round-robin then favours the other requester if it is requesting.
- fbw_row_rdy=0 in IDLE blocks any grant.
- rq_req in both bits while in OWN: no effect until release.
- Reset mid-transaction: grant and strobes drop immediately (async); no partial strobe is emitted after rst is asserted.
- Watchdog counter width is $clog2(TIMEOUT+1). With TIMEOUT=0 the counter is held at 0 and err_timeout stays 0.
- rq_gnt is never two-hot. fbw_* strobes are 0 whenever rq_gnt=0.

Test Plan:
- Single owner: rq_req=01 with fbw_row_rdy=1; write cols 0..63 with data 0x0000FF, row_store with row_addr=5, drop req. Expect rq_gnt=01 one cycle after req; 64 fbw_wren pulses with matching col/data; one fbw_row_store with row_addr=5; gnt=00 one cycle after req drops.
- Tie and round-robin: from reset, rq_req=11 held and each owner releases after 3 writes. Expect grant order 0,1,0,1; requester 1 strobes while not granted never appear on fbw_*.
- Drain gating: owner 0 issues row_store and releases while fbw_row_rdy is held 0 for 10 cycles, with rq_req=10 pending. Expect rq_gnt=10 no earlier than 2 cycles after fbw_row_rdy rises.
- Watchdog: TIMEOUT=16; owner 1 granted, one wren, then idle. Expect gnt dropped and err_timeout pulsed exactly 16 cycles after the last wren; with rq_req=11 held, next grant goes to requester 0.
- Activity at expiry: TIMEOUT=16; wren issued on cycle 15 of idleness. Expect no err_timeout and the counter restarting from 0.
- Async reset: assert rst during an owner 0 row_swap. Expect rq_gnt=00 and all fbw_* strobes 0 immediately; after release, a rq_req=11 tie grants requester 0.

Source files
------------

// File: rtl/fbw_arbiter.sv
// fbw_arbiter -- shares the single frame-buffer write port between two
// requesters (typically 0 = SPI video stream, 1 = pattern/overlay generator).
//
// Whole transactions are granted: pixel writes plus row store/swap and frame
// swap all travel under one grant. Arbitration is round-robin and only
// happens in IDLE with the back buffer ready. A watchdog revokes a grant whose
// owner goes quiet for TIMEOUT cycles (TIMEOUT = 0 disables it).
//
// Handshake: a requester raises rq_req[i] and holds it for the whole
// transaction. rq_gnt[i] rises one cycle after the request is first sampled in
// IDLE. Strobes count only in cycles where rq_req[i] and rq_gnt[i] are both
// high. Dropping rq_req[i] ends the transaction and rq_gnt[i] falls on the
// next edge. A requester must watch rq_gnt, because the watchdog can also
// drop it.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rq_req[1:0]           per-requester request
//   rq_gnt[1:0]           per-requester grant (one-hot or zero)
//   rq_row_addr, rq_row_store, rq_row_swap, rq_frame_swap,
//   rq_data, rq_col_addr, rq_wren
//                         per-requester write-port slices (slice i = requester i)
//   fbw_*                 muxed write port to the frame buffer
//   fbw_row_rdy           back-buffer ready from the frame buffer
//   err_timeout           one-cycle pulse when the watchdog revokes a grant
//   dbg_state             current FSM state (0 IDLE, 1 OWN, 2 DRAIN)
module fbw_arbiter #(
  parameter int N_ROWS     = 64,
  parameter int N_COLS     = 64,
  parameter int TIMEOUT    = 4096,
  parameter int LOG_N_ROWS = $clog2(N_ROWS),
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              rq_req,
  output logic [1:0]              rq_gnt,
  input  logic [2*LOG_N_ROWS-1:0] rq_row_addr,
  input  logic [1:0]              rq_row_store,
  input  logic [1:0]              rq_row_swap,
  input  logic [1:0]              rq_frame_swap,
  input  logic [47:0]             rq_data,
  input  logic [2*LOG_N_COLS-1:0] rq_col_addr,
  input  logic [1:0]              rq_wren,
  output logic [LOG_N_ROWS-1:0]   fbw_row_addr,
  output logic                    fbw_row_store,
  output logic                    fbw_row_swap,
  output logic                    fbw_frame_swap,
  output logic [23:0]             fbw_data,
  output logic [LOG_N_COLS-1:0]   fbw_col_addr,
  output logic                    fbw_wren,
  input  logic                    fbw_row_rdy,
  output logic                    err_timeout,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // The counter is kept 1 bit wide when the watchdog is disabled, so its
  // declaration stays legal; it is then held at zero.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic owner;
  logic owner_req;
  logic fwd;
  logic owner_act;

  // gnt_q is one-hot in OWN, so bit 1 names the owner directly.
  assign owner     = gnt_q[1];
  assign owner_req = rq_req[owner];
  // The owner's slice passes through only while it holds both gnt and req.
  // In the cycle its req is sampled low, its strobes are therefore dropped.
  assign fwd       = (state_q == S_OWN) && (gnt_q != 2'b00) && owner_req;
  assign owner_act = fwd && (rq_wren[owner] || rq_row_store[owner] ||
                             rq_row_swap[owner] || rq_frame_swap[owner]);

  assign rq_gnt      = gnt_q;
  assign err_timeout = err_q;
  assign dbg_state   = state_q;

  always_comb begin
    fbw_row_addr   = '0;
    fbw_row_store  = 1'b0;
    fbw_row_swap   = 1'b0;
    fbw_frame_swap = 1'b0;
    fbw_data       = '0;
    fbw_col_addr   = '0;
    fbw_wren       = 1'b0;
    if (fwd) begin
      fbw_row_addr   = owner ? rq_row_addr[2*LOG_N_ROWS-1:LOG_N_ROWS]
                             : rq_row_addr[LOG_N_ROWS-1:0];
      fbw_col_addr   = owner ? rq_col_addr[2*LOG_N_COLS-1:LOG_N_COLS]
                             : rq_col_addr[LOG_N_COLS-1:0];
      fbw_data       = owner ? rq_data[47:24] : rq_data[23:0];
      fbw_row_store  = rq_row_store[owner];
      fbw_row_swap   = rq_row_swap[owner];
      fbw_frame_swap = rq_frame_swap[owner];
      fbw_wren       = rq_wren[owner];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if ((rq_req != 2'b00) && fbw_row_rdy) begin
          state_d = S_OWN;
          // On a tie the requester that did not own the port last time wins.
          if (rq_req == 2'b11) gnt_d = last_q ? 2'b01 : 2'b10;
          else                 gnt_d = rq_req;
        end
      end
      S_OWN: begin
        if (!owner_req) begin
          gnt_d   = 2'b00;
          last_d  = owner;
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else if (TIMEOUT == 0) begin
          cnt_d = '0;
        end else if (owner_act) begin
          // Activity takes priority, including in the expiry cycle.
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          gnt_d   = 2'b00;
          err_d   = 1'b1;
          last_d  = owner;
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        // Hold off the next owner until any row store in flight has finished.
        gnt_d = 2'b00;
        if (fbw_row_rdy) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fbw_arbiter.sv
// Directed testbench for fbw_arbiter (N_ROWS = N_COLS = 64, TIMEOUT = 16).
module tb_fbw_arbiter;

  localparam int LR = 6;
  localparam int LC = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rq_req;
  logic [1:0]    rq_gnt;
  logic [2*LR-1:0] rq_row_addr;
  logic [1:0]    rq_row_store;
  logic [1:0]    rq_row_swap;
  logic [1:0]    rq_frame_swap;
  logic [47:0]   rq_data;
  logic [2*LC-1:0] rq_col_addr;
  logic [1:0]    rq_wren;
  logic [LR-1:0] fbw_row_addr;
  logic          fbw_row_store;
  logic          fbw_row_swap;
  logic          fbw_frame_swap;
  logic [23:0]   fbw_data;
  logic [LC-1:0] fbw_col_addr;
  logic          fbw_wren;
  logic          fbw_row_rdy;
  logic          err_timeout;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  fbw_arbiter #(.N_ROWS(64), .N_COLS(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rq_req(rq_req), .rq_gnt(rq_gnt),
    .rq_row_addr(rq_row_addr), .rq_row_store(rq_row_store),
    .rq_row_swap(rq_row_swap), .rq_frame_swap(rq_frame_swap),
    .rq_data(rq_data), .rq_col_addr(rq_col_addr), .rq_wren(rq_wren),
    .fbw_row_addr(fbw_row_addr), .fbw_row_store(fbw_row_store),
    .fbw_row_swap(fbw_row_swap), .fbw_frame_swap(fbw_frame_swap),
    .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren),
    .fbw_row_rdy(fbw_row_rdy), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rq_req        = 2'b00;
    rq_row_addr   = '0;
    rq_row_store  = 2'b00;
    rq_row_swap   = 2'b00;
    rq_frame_swap = 2'b00;
    rq_data       = '0;
    rq_col_addr   = '0;
    rq_wren       = 2'b00;
    fbw_row_rdy   = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    checks++;
    if (rq_gnt !== 2'b00) begin
      failures++; $display("FAIL reset_gnt: got %b expected 00", rq_gnt);
    end
    checks++;
    if ({fbw_wren, fbw_row_store, fbw_row_swap, fbw_frame_swap, err_timeout} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {fbw_wren, fbw_row_store, fbw_row_swap, fbw_frame_swap, err_timeout});
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_owner();
    int pulses;
    do_reset();
    rq_req = 2'b01;
    #1;
    checks++;
    if (rq_gnt !== 2'b00) begin
      failures++; $display("FAIL single_gnt_early: got %b expected 00", rq_gnt);
    end
    step();
    checks++;
    if (rq_gnt !== 2'b01) begin
      failures++; $display("FAIL single_gnt: got %b expected 01", rq_gnt);
    end
    pulses = 0;
    for (int col = 0; col < 64; col++) begin
      // Requester 1 strobes too, with different col/data, and must not leak.
      rq_wren              = 2'b11;
      rq_col_addr[LC-1:0]  = 6'(col);
      rq_col_addr[2*LC-1:LC] = 6'(63 - col);
      rq_data[23:0]        = 24'h0000FF;
      rq_data[47:24]       = 24'hABCDEF;
      #1;
      checks++;
      if ({fbw_wren, fbw_col_addr, fbw_data} !== {1'b1, 6'(col), 24'h0000FF}) begin
        failures++;
        $display("FAIL single_write col %0d: got wren=%b col=%0d data=%h expected 1/%0d/0000ff",
                 col, fbw_wren, fbw_col_addr, fbw_data, col);
      end
      if (fbw_wren === 1'b1) pulses++;
      step();
    end
    rq_wren = 2'b00;
    checks++;
    if (pulses !== 64) begin
      failures++; $display("FAIL single_pulses: got %0d expected 64", pulses);
    end
    rq_row_store       = 2'b01;
    rq_row_addr[LR-1:0] = 6'd5;
    rq_row_addr[2*LR-1:LR] = 6'd33;
    #1;
    checks++;
    if ({fbw_row_store, fbw_row_addr, fbw_wren} !== {1'b1, 6'd5, 1'b0}) begin
      failures++;
      $display("FAIL single_row_store: got store=%b row=%0d wren=%b expected 1/5/0",
               fbw_row_store, fbw_row_addr, fbw_wren);
    end
    step();
    rq_row_store = 2'b00;
    rq_req       = 2'b00;
    rq_wren      = 2'b01;   // presented while req is low: must be ignored
    #1;
    checks++;
    if (fbw_wren !== 1'b0) begin
      failures++; $display("FAIL single_wren_req_low: got %b expected 0", fbw_wren);
    end
    step();
    rq_wren = 2'b00;
    checks++;
    if ({rq_gnt, dbg_state} !== {2'b00, 2'd2}) begin
      failures++;
      $display("FAIL single_release: got gnt=%b state=%0d expected 00/2", rq_gnt, dbg_state);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [4];
    int waited;
    int own;
    logic [23:0] d;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    do_reset();
    rq_req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      while (rq_gnt === 2'b00 && waited < 10) begin
        step();
        waited++;
      end
      checks++;
      if (rq_gnt !== exp_gnt[g]) begin
        failures++;
        $display("FAIL rr_grant %0d: got %b expected %b (waited %0d)", g, rq_gnt, exp_gnt[g], waited);
      end
      own = (exp_gnt[g] == 2'b10) ? 1 : 0;
      for (int w = 0; w < 3; w++) begin
        d = 24'h100000 + 24'(g * 16 + w);
        rq_wren = 2'b11;
        if (own == 1) begin
          rq_data = {d, 24'hDEAD00};
          rq_col_addr = {6'(w), 6'h3F};
        end else begin
          rq_data = {24'hDEAD00, d};
          rq_col_addr = {6'h3F, 6'(w)};
        end
        #1;
        checks++;
        if ({fbw_wren, fbw_data, fbw_col_addr} !== {1'b1, d, 6'(w)}) begin
          failures++;
          $display("FAIL rr_write g%0d w%0d: got wren=%b data=%h col=%0d expected 1/%h/%0d",
                   g, w, fbw_wren, fbw_data, fbw_col_addr, d, w);
        end
        step();
      end
      rq_wren = 2'b00;
      rq_req[own] = 1'b0;
      step();
      // Now in DRAIN: nobody's strobes may reach the port.
      rq_wren      = 2'b11;
      rq_row_store = 2'b11;
      #1;
      checks++;
      if ({rq_gnt, fbw_wren, fbw_row_store} !== 4'b0000) begin
        failures++;
        $display("FAIL rr_drain_leak g%0d: got gnt=%b wren=%b store=%b expected 00/0/0",
                 g, rq_gnt, fbw_wren, fbw_row_store);
      end
      rq_wren      = 2'b00;
      rq_row_store = 2'b00;
      rq_req       = 2'b11;
      step();
    end
    rq_req = 2'b00;
    step();
    step();
  endtask

  task automatic test_drain_gating();
    do_reset();
    rq_req = 2'b01;
    step();
    checks++;
    if (rq_gnt !== 2'b01) begin
      failures++; $display("FAIL drain_first_gnt: got %b expected 01", rq_gnt);
    end
    rq_row_store        = 2'b01;
    rq_row_addr[LR-1:0] = 6'd9;
    step();
    rq_row_store = 2'b00;
    fbw_row_rdy  = 1'b0;
    rq_req       = 2'b10;
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rq_gnt !== 2'b00) begin
        failures++; $display("FAIL drain_hold %0d: got %b expected 00", i, rq_gnt);
      end
      step();
    end
    fbw_row_rdy = 1'b1;
    #1;
    checks++;
    if (rq_gnt !== 2'b00) begin
      failures++; $display("FAIL drain_rdy_rise: got %b expected 00", rq_gnt);
    end
    step();
    checks++;
    if ({rq_gnt, dbg_state} !== {2'b00, 2'd0}) begin
      failures++;
      $display("FAIL drain_idle: got gnt=%b state=%0d expected 00/0", rq_gnt, dbg_state);
    end
    step();
    checks++;
    if (rq_gnt !== 2'b10) begin
      failures++; $display("FAIL drain_next_gnt: got %b expected 10", rq_gnt);
    end
    rq_req = 2'b00;
    step();
    step();
  endtask

  task automatic test_watchdog();
    do_reset();
    rq_req = 2'b10;
    step();
    checks++;
    if (rq_gnt !== 2'b10) begin
      failures++; $display("FAIL wd_gnt: got %b expected 10", rq_gnt);
    end
    rq_wren = 2'b10;
    step();
    rq_wren = 2'b00;
    rq_req  = 2'b11;
    for (int j = 1; j < TO; j++) begin
      step();
      checks++;
      if ({rq_gnt, err_timeout} !== {2'b10, 1'b0}) begin
        failures++;
        $display("FAIL wd_hold %0d: got gnt=%b err=%b expected 10/0", j, rq_gnt, err_timeout);
      end
    end
    step();
    checks++;
    if ({rq_gnt, err_timeout} !== {2'b00, 1'b1}) begin
      failures++;
      $display("FAIL wd_expire: got gnt=%b err=%b expected 00/1", rq_gnt, err_timeout);
    end
    step();
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++; $display("FAIL wd_pulse_width: got %b expected 0", err_timeout);
    end
    step();
    checks++;
    if (rq_gnt !== 2'b01) begin
      failures++; $display("FAIL wd_next_gnt: got %b expected 01", rq_gnt);
    end
    rq_req = 2'b00;
    step();
    step();
  endtask

  task automatic test_activity_at_expiry();
    do_reset();
    rq_req = 2'b01;
    step();
    rq_wren = 2'b01;
    step();
    rq_wren = 2'b00;
    repeat (TO - 1) step();
    rq_wren = 2'b01;
    #1;
    checks++;
    if (fbw_wren !== 1'b1) begin
      failures++; $display("FAIL exp_forward: got %b expected 1", fbw_wren);
    end
    step();
    rq_wren = 2'b00;
    checks++;
    if ({rq_gnt, err_timeout} !== {2'b01, 1'b0}) begin
      failures++;
      $display("FAIL exp_no_timeout: got gnt=%b err=%b expected 01/0", rq_gnt, err_timeout);
    end
    for (int j = 1; j < TO; j++) begin
      step();
      checks++;
      if ({rq_gnt, err_timeout} !== {2'b01, 1'b0}) begin
        failures++;
        $display("FAIL exp_restart %0d: got gnt=%b err=%b expected 01/0", j, rq_gnt, err_timeout);
      end
    end
    step();
    checks++;
    if ({rq_gnt, err_timeout} !== {2'b00, 1'b1}) begin
      failures++;
      $display("FAIL exp_second_expire: got gnt=%b err=%b expected 00/1", rq_gnt, err_timeout);
    end
    rq_req = 2'b00;
    step();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    rq_req = 2'b01;
    step();
    rq_row_swap = 2'b01;
    #1;
    checks++;
    if (fbw_row_swap !== 1'b1) begin
      failures++; $display("FAIL async_swap_before: got %b expected 1", fbw_row_swap);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rq_gnt, fbw_wren, fbw_row_store, fbw_row_swap, fbw_frame_swap, err_timeout} !== 7'b0) begin
      failures++;
      $display("FAIL async_drop: got gnt=%b strobes=%b expected 00/00000", rq_gnt,
               {fbw_wren, fbw_row_store, fbw_row_swap, fbw_frame_swap, err_timeout});
    end
    step();
    rq_row_swap = 2'b00;
    rst         = 1'b0;
    rq_req      = 2'b11;
    step();
    checks++;
    if (rq_gnt !== 2'b01) begin
      failures++; $display("FAIL async_tie_after: got %b expected 01", rq_gnt);
    end
    rq_req = 2'b00;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_owner();
    test_round_robin();
    test_drain_gating();
    test_watchdog();
    test_activity_at_expiry();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
